// File: rtl/paralelo_serial1.sv
// LSB-first 8:1 serializer for the lane transmitter: comma preamble after reset,
// then one upstream word (or an idle comma) every 8 bit clocks.
module paralelo_serial1 #(
    parameter logic [7:0] COMMA      = 8'hBC,
    parameter int         SYNC_WORDS = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       data_out,
    output logic       ld_strobe,
    output logic       active,
    output logic       sending_data
);

    localparam logic [0:0] ST_SYNC   = 1'b0;
    localparam logic [0:0] ST_RUN    = 1'b1;
    localparam logic [2:0] SYNC_LAST = 3'(SYNC_WORDS - 1);

    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] word_q, word_d;
    logic [2:0] sync_cnt_q, sync_cnt_d;
    logic [0:0] state_q, state_d;
    logic       data_out_q, data_out_d;
    logic       active_q, active_d;
    logic       sending_q, sending_d;
    logic       load_edge;

    always_comb begin
        load_edge  = (bit_cnt_q == 3'd7);
        // The final preamble load already samples upstream, so the first data
        // word follows the last comma without a gap.
        ld_strobe  = load_edge && ((state_q == ST_RUN) || (sync_cnt_q == SYNC_LAST));

        bit_cnt_d  = bit_cnt_q + 3'd1;
        data_out_d = word_q[bit_cnt_q];
        word_d     = word_q;
        sync_cnt_d = sync_cnt_q;
        state_d    = state_q;
        active_d   = active_q;
        sending_d  = sending_q;

        if (ld_strobe) begin
            word_d    = valid_in ? data_in : COMMA;
            sending_d = valid_in;
            state_d   = ST_RUN;
            active_d  = 1'b1;
        end else if (load_edge) begin
            word_d     = COMMA;
            sync_cnt_d = sync_cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            bit_cnt_q  <= 3'd0;
            word_q     <= COMMA;
            sync_cnt_q <= 3'd0;
            state_q    <= ST_SYNC;
            data_out_q <= 1'b0;
            active_q   <= 1'b0;
            sending_q  <= 1'b0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            word_q     <= word_d;
            sync_cnt_q <= sync_cnt_d;
            state_q    <= state_d;
            data_out_q <= data_out_d;
            active_q   <= active_d;
            sending_q  <= sending_d;
        end
    end

    assign data_out     = data_out_q;
    assign active       = active_q;
    assign sending_data = sending_q;

endmodule

// File: doc/paralelo_serial1.md
Name: paralelo_serial1

Overview:
- Transmit-side counterpart of the lane's serial-to-parallel receiver. It serializes 8-bit parallel words LSB-first onto a single bit line at the 32f rate.
- Idle words are sent as the comma 0xBC. After reset, a mandatory preamble of SYNC_WORDS commas is sent so the far-end receiver can assert active before any data arrives.
- It sits between the upstream byte-wide path (4f domain, fed via ld_strobe) and the serial line.

Parameters:
- COMMA, 8'hBC, idle/alignment word, transmitted whenever no valid data is present.
- SYNC_WORDS, 4, number of commas forced after reset before data is accepted; legal range 1..7.

Ports:
- clk_32f  input  1  serial bit clock; all logic on posedge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- data_in  input  8  parallel word, sampled only at a load edge.
- valid_in  input  1  data_in is valid; sampled together with data_in.
- data_out  output  1  registered serial bit, LSB first.
- ld_strobe  output  1  combinational; high for the one cycle before a load edge in which data_in/valid_in are sampled.
- active  output  1  preamble complete; the block is accepting upstream words.
- sending_data  output  1  high while the word currently being shifted out came from valid_in=1.

Behaviour:
- Reset (reset=0, async):
  - Outputs: data_out=0, active=0, sending_data=0.
  - Internal: bit_cnt=0, word_reg=COMMA, sync_cnt=0, state=SYNC.
  - Reset mid-word aborts immediately; no partial word is completed.
- Bit counter:
  - bit_cnt (3 bits) increments every posedge and wraps 7->0.
  - One word = 8 clk_32f cycles; this is the only word framing.
- Serializer:
  - Each posedge: data_out <= word_reg[bit_cnt].
  - Serial latency is one cycle from word_reg bit select to pin.
  - The first bit after reset release appears after edge 1.
- Load edge: any posedge where bit_cnt==7 reloads word_reg for the next word.
- State SYNC:
  - At each load edge with sync_cnt < SYNC_WORDS-1: word_reg <= COMMA; sync_cnt++; ld_strobe=0.
  - At the load edge with sync_cnt == SYNC_WORDS-1: ld_strobe=1, data is sampled as in RUN, state -> RUN, active <= 1.
  - Result: exactly SYNC_WORDS commas precede the first upstream word, counting the reset-loaded word_reg.
- State RUN:
  - ld_strobe=1 whenever bit_cnt==7.
  - At the load edge: word_reg <= valid_in ? data_in : COMMA; sending_data <= valid_in.
  - active stays 1 until reset; there is no return to SYNC without reset.
- valid_in and data_in are ignored at all non-load edges. Upstream must hold them stable through the ld_strobe cycle.
- valid_in=1 with data_in==COMMA:
  - Transmitted unchanged; sending_data=1.
  - The far end will treat this word as idle. This is upstream's responsibility, and no error is flagged.
- Back-to-back valid words produce no gap; one word is emitted every 8 cycles.
- sync_cnt saturates at its final value in RUN.

Test Plan:
- Reset then release, valid_in=0 throughout -> data_out after edges 1..8 = 0,0,1,1,1,1,0,1 (0xBC LSB first), repeating. ld_strobe first high between edges 31 and 32. active rises after edge 32. sending_data stays 0.
- After preamble, data_in=8'hA5, valid_in=1 in the ld_strobe cycle before edge 32 -> bits after edges 33..40 = 1,0,1,0,0,1,0,1. sending_data=1 from edge 32 to edge 40.
- Back-to-back words 8'h01, 8'hFF, 8'h80 on consecutive ld_strobes -> contiguous 24-bit stream 10000000 11111111 00000001 with no commas between. sending_data held 1.
- Valid word 8'h3C followed by valid_in=0 -> 0,0,1,1,1,1,0,0 then comma 0,0,1,1,1,1,0,1. sending_data drops after the next load edge.
- reset pulsed low mid-word (bit_cnt=4, RUN) -> data_out=0 and active=0 asynchronously. After release, the full SYNC_WORDS-comma preamble is repeated before ld_strobe.
- SYNC_WORDS=1 -> ld_strobe high in the first bit_cnt==7 cycle; active after edge 8; first data bit after edge 9.
